// File: rtl/rv32e_pkg.sv
// rv32e_pkg: shared encodings for the RV32E load/store unit.
//   SIZE_*      : request access-size encodings (2'b11 is illegal)
//   lsu_state_e : LSU controller states
package rv32e_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LWAIT,
        STORE,
        RESP
    } lsu_state_e;

endpackage

// File: rtl/rv32e_lsu_align.sv
// rv32e_lsu_align: purely combinational alignment helper.
//   off_i/size_i    -> misalign_o (misaligned or illegal size)
//   wdata_i         -> be_o, wdata_o (lane mask and lane-replicated store data)
//   rdata_i, uns_i  -> rdata_o (load word shifted to bit 0, then sign/zero extended)
module rv32e_lsu_align
    import rv32e_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic        misalign_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        misalign_o = 1'b0;
        be_o       = 4'b0000;
        wdata_o    = 32'h0;
        rdata_o    = 32'h0;
        // Byte offset times 8 moves the addressed lane down to bit 0.
        shifted    = rdata_i >> {off_i, 3'b000};
        case (size_i)
            SIZE_B: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = uns_i ? {24'h0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                misalign_o = off_i[0];
                be_o       = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = uns_i ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
            end
            SIZE_W: begin
                misalign_o = (off_i != 2'b00);
                be_o       = 4'b1111;
                wdata_o    = wdata_i;
                rdata_o    = rdata_i;
            end
            default: misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32e_lsu.sv
// rv32e_lsu: load/store unit between the execute stage and the data RAM.
//   req_*  : CPU request (valid/ready handshake, accepted only in IDLE)
//   resp_* : response (valid/ready), rdata extended, fault on misalign/illegal
//   mem_*  : word-aligned RAM port with one-cycle read/write strobes,
//            read data returned the cycle after mem_read_enable
module rv32e_lsu
    import rv32e_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault,
    output logic [ADDR_WIDTH-1:0] mem_addr_bus,
    output logic                  mem_read_enable,
    input  logic [DATA_WIDTH-1:0] mem_read_data_bus,
    output logic                  mem_write_enable,
    output logic [3:0]            mem_byte_enable,
    output logic [DATA_WIDTH-1:0] mem_write_data_bus
);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic                  we_q;
    logic                  uns_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  fault_q;

    logic        hs;
    logic        run;
    logic [1:0]  al_off;
    logic [1:0]  al_size;
    logic        al_misalign;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;

    // Outputs are forced quiet while reset is held, whatever the state.
    assign run = ~reset;
    assign hs  = req_valid & req_ready;

    // The fault decision must be made on the live request in IDLE (faults
    // respond at N+1); every later use works from the captured request.
    assign al_off  = (state_q == IDLE) ? req_addr[1:0] : addr_q[1:0];
    assign al_size = (state_q == IDLE) ? req_size      : size_q;

    rv32e_lsu_align u_align (
        .off_i      (al_off),
        .size_i     (al_size),
        .uns_i      (uns_q),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_read_data_bus),
        .misalign_o (al_misalign),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    if (al_misalign) state_d = RESP;
                    else if (req_we) state_d = STORE;
                    else             state_d = LOAD;
                end
            end
            LOAD:    state_d = LWAIT;
            LWAIT:   state_d = RESP;
            STORE:   state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata;
                rdata_q <= '0;   // stores and faults respond with zero data
                fault_q <= al_misalign;
            end
            if (state_q == LWAIT) rdata_q <= al_rdata;
        end
    end

    always_comb begin
        req_ready          = run && (state_q == IDLE);
        resp_valid         = run && (state_q == RESP);
        resp_rdata         = resp_valid ? rdata_q : '0;
        resp_fault         = resp_valid & fault_q;
        mem_read_enable    = run && (state_q == LOAD);
        mem_write_enable   = run && (state_q == STORE) && we_q;
        mem_addr_bus       = (mem_read_enable || mem_write_enable)
                             ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
        mem_byte_enable    = mem_write_enable ? al_be : 4'b0000;
        mem_write_data_bus = mem_write_enable ? al_wdata : '0;
    end

endmodule

// File: tb/tb_rv32e_lsu.sv
module tb_rv32e_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_fault;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr_bus, mem_read_data_bus, mem_write_data_bus;
    logic        mem_read_enable, mem_write_enable;
    logic [3:0]  mem_byte_enable;

    int checks = 0;
    int failures = 0;

    logic [31:0] ram [0:255];

    always #5 clk = ~clk;

    rv32e_lsu dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_we             (req_we),
        .req_size           (req_size),
        .req_unsigned       (req_unsigned),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .resp_valid         (resp_valid),
        .resp_ready         (resp_ready),
        .resp_rdata         (resp_rdata),
        .resp_fault         (resp_fault),
        .mem_addr_bus       (mem_addr_bus),
        .mem_read_enable    (mem_read_enable),
        .mem_read_data_bus  (mem_read_data_bus),
        .mem_write_enable   (mem_write_enable),
        .mem_byte_enable    (mem_byte_enable),
        .mem_write_data_bus (mem_write_data_bus)
    );

    // RAM model: registered read, byte-masked write.
    always @(posedge clk) begin
        if (mem_read_enable) mem_read_data_bus <= ram[mem_addr_bus[9:2]];
        if (mem_write_enable)
            for (int b = 0; b < 4; b++)
                if (mem_byte_enable[b]) ram[mem_addr_bus[9:2]][8*b +: 8] <= mem_write_data_bus[8*b +: 8];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                          input logic [31:0] exp_rd, input logic exp_f, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdb, input int hold);
        int cyc, rd, wr;
        logic [31:0] a, wdb;
        logic [3:0]  be;
        resp_ready   = (hold == 0);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        check({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
        tick();
        req_valid = 1'b0;
        cyc = 1; rd = 0; wr = 0; a = 0; be = 0; wdb = 0;
        while (!resp_valid && cyc < 10) begin
            if (mem_read_enable) begin rd++; a = mem_addr_bus; end
            if (mem_write_enable) begin
                wr++; a = mem_addr_bus; be = mem_byte_enable; wdb = mem_write_data_bus;
            end
            tick();
            cyc++;
        end
        if (mem_read_enable) rd++;
        if (mem_write_enable) wr++;
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_fault"}, {31'h0, resp_fault}, {31'h0, exp_f});
        check({tag, "_rdata"}, resp_rdata, exp_rd);
        check({tag, "_rd_strobes"}, rd, (!we && !exp_f) ? 1 : 0);
        check({tag, "_wr_strobes"}, wr, (we && !exp_f) ? 1 : 0);
        if (!exp_f) check({tag, "_mem_addr"}, a, {addr[31:2], 2'b00});
        if (we && !exp_f) begin
            check({tag, "_be"}, {28'h0, be}, {28'h0, exp_be});
            check({tag, "_wdata_bus"}, wdb, exp_wdb);
        end
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_valid"}, {31'h0, resp_valid}, 32'h1);
            check({tag, "_hold_rdata"}, resp_rdata, exp_rd);
            check({tag, "_hold_fault"}, {31'h0, resp_fault}, {31'h0, exp_f});
            check({tag, "_hold_req_ready"}, {31'h0, req_ready}, 32'h0);
            tick();
        end
        if (hold > 0) check({tag, "_valid_at_accept"}, {31'h0, resp_valid}, 32'h1);
        resp_ready = 1'b1;
        tick();
        check({tag, "_done_valid"}, {31'h0, resp_valid}, 32'h0);
        check({tag, "_done_ready"}, {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[32'h200 >> 2] = 32'h80FF7F01;
        mem_read_data_bus = 32'h0;
        reset = 1'b1; resp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h200; req_wdata = 32'h0;

        // Reset held 3 cycles with a request pending.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        end
        check("rst_strobes", {28'h0, mem_read_enable, mem_write_enable, resp_valid, resp_fault}, 32'h0);
        check("rst_mem_addr", mem_addr_bus, 32'h0);
        check("rst_mem_be_wd", {28'h0, mem_byte_enable} | mem_write_data_bus, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        reset = 1'b0; req_valid = 1'b0;
        #1;
        check("post_rst_ready", {31'h0, req_ready}, 32'h1);
        tick();

        // Stores
        do_req("sw",  1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 2, 32'h0, 0, 4'b1111, 32'hDEADBEEF, 0);
        do_req("sh",  1, 2'b01, 0, 32'h102, 32'h1234ABCD, 2, 32'h0, 0, 4'b1100, 32'hABCDABCD, 0);
        do_req("sb",  1, 2'b00, 0, 32'h101, 32'h00000055, 2, 32'h0, 0, 4'b0010, 32'h55555555, 0);
        do_req("lw_back", 0, 2'b10, 0, 32'h100, 32'h0, 3, 32'hABCD55EF, 0, 4'b0, 32'h0, 0);

        // Loads from 0x80FF7F01 at 0x200
        do_req("lb",  0, 2'b00, 0, 32'h203, 32'h0, 3, 32'hFFFFFF80, 0, 4'b0, 32'h0, 0);
        do_req("lbu", 0, 2'b00, 1, 32'h203, 32'h0, 3, 32'h00000080, 0, 4'b0, 32'h0, 0);
        do_req("lh",  0, 2'b01, 0, 32'h202, 32'h0, 3, 32'hFFFF80FF, 0, 4'b0, 32'h0, 0);
        do_req("lhu0", 0, 2'b01, 1, 32'h200, 32'h0, 3, 32'h00007F01, 0, 4'b0, 32'h0, 0);
        do_req("lw",  0, 2'b10, 0, 32'h200, 32'h0, 3, 32'h80FF7F01, 0, 4'b0, 32'h0, 0);

        // Faults
        do_req("f_lw",   0, 2'b10, 0, 32'h101, 32'h0, 1, 32'h0, 1, 4'b0, 32'h0, 0);
        do_req("f_sh",   1, 2'b01, 0, 32'h103, 32'h1111, 1, 32'h0, 1, 4'b0, 32'h0, 0);
        do_req("f_size", 0, 2'b11, 0, 32'h200, 32'h0, 1, 32'h0, 1, 4'b0, 32'h0, 0);

        // Backpressure: 4 cycles of resp_ready=0, then back-to-back request
        do_req("bp_lh", 0, 2'b01, 0, 32'h202, 32'h0, 3, 32'hFFFF80FF, 0, 4'b0, 32'h0, 4);
        do_req("bp_next", 0, 2'b00, 1, 32'h200, 32'h0, 3, 32'h00000001, 0, 4'b0, 32'h0, 0);

        // Reset while in LOAD
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h200;
        tick();
        req_valid = 1'b0;
        check("rl_in_load_strobe", {31'h0, mem_read_enable}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rl_idle_ready", {31'h0, req_ready}, 32'h1);
        begin
            int bad = 0;
            for (int i = 0; i < 6; i++) begin
                if (resp_valid || mem_read_enable || mem_write_enable) bad++;
                tick();
            end
            check("rl_no_resp_or_strobe", bad, 0);
        end
        do_req("rl_after", 0, 2'b10, 0, 32'h200, 32'h0, 3, 32'h80FF7F01, 0, 4'b0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
